// File: rtl/k2_result_uart_tx.sv
// k2_result_uart_tx: queues each new K2 result byte and sends it as UART 8N1 on tx.
module k2_result_uart_tx #(
   parameter int CLKS_PER_BIT  = 868,
   parameter int DEPTH         = 4,
   parameter bit CHANGE_DETECT = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [7:0]               result_in,
   input  logic                     result_valid,
   output logic                     tx,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     overflow
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [1:0] IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3;
   localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);
   logic [1:0]    state;
   logic [15:0]   timer;
   logic [2:0]    bit_idx;
   logic [7:0]    shift, prev_result;
   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          push, pop, wr_en, full, empty, bit_end;
   assign bit_end = timer == LAST;
   assign empty   = fifo_count == '0;
   assign full    = fifo_count == CW'(DEPTH);
   assign push    = CHANGE_DETECT ? result_in != prev_result : result_valid;
   // a pop at the end of a stop bit chains the next frame with no idle gap
   assign pop     = !empty && (state == IDLE || (state == STOP && bit_end));
   assign wr_en   = push && (!full || pop);
   assign busy    = (state != IDLE) || !empty;
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= result_in;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         fifo_count  <= '0;
         overflow    <= 1'b0;
         prev_result <= 8'h00;
      end else begin
         prev_result <= result_in;
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         if (push && !wr_en) overflow <= 1'b1;
         fifo_count <= fifo_count + CW'(wr_en) - CW'(pop);
      end
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         timer   <= '0;
         bit_idx <= '0;
         shift   <= '0;
         tx      <= 1'b1;
      end else begin
         case (state)
            IDLE: if (pop) begin
               shift <= mem[rd_ptr];
               state <= START;
               timer <= '0;
               tx    <= 1'b0;
            end
            START: if (bit_end) begin
               state   <= DATA;
               timer   <= '0;
               bit_idx <= '0;
               tx      <= shift[0];
            end else timer <= timer + 16'd1;
            DATA: if (bit_end) begin
               timer <= '0;
               if (bit_idx == 3'd7) begin
                  state <= STOP;
                  tx    <= 1'b1;
               end else begin
                  bit_idx <= bit_idx + 3'd1;
                  shift   <= shift >> 1;
                  tx      <= shift[1];
               end
            end else timer <= timer + 16'd1;
            default: if (bit_end) begin
               timer <= '0;
               if (pop) begin
                  shift <= mem[rd_ptr];
                  state <= START;
                  tx    <= 1'b0;
               end else state <= IDLE;
            end else timer <= timer + 16'd1;
         endcase
      end
   end
endmodule

// File: doc/k2_result_uart_tx.md
Name: k2_result_uart_tx

Overview:
- Downstream consumer of the K2 processor's 8-bit `result` output.
- Detects each new result value and queues it in a small FIFO.
- Serialises each queued value as UART 8N1 on a single `tx` pin, so program output can be observed off-chip or on the bench without probing RAout/RBout.
- Sits between K2_process and the board pin; shares K2's clock and reset.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); legal range 2..65535.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- CHANGE_DETECT, 1, 1 = push when result_in changes; 0 = push on result_valid strobe.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset; resets every register to the values below.
- result_in  input  8  K2 `result` bus.
- result_valid  input  1  push strobe; used only when CHANGE_DETECT=0, ignored otherwise.
- tx  output  1  UART serial out, idle high.
- busy  output  1  high while the FIFO is non-empty or a frame is in progress.
- fifo_count  output  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow  output  1  sticky flag: a push was dropped because the FIFO was full.

Behaviour:
- Reset (reset=0, asynchronous):
  - tx=1, busy=0, fifo_count=0, overflow=0.
  - FSM=IDLE; prev_result=8'h00; FIFO pointers=0.
- Push condition:
  - CHANGE_DETECT=1: push when result_in != prev_result at a rising edge. prev_result <= result_in on every edge.
  - Consequence: a result that stays 8'h00 after reset is never sent.
  - CHANGE_DETECT=0: push on every edge where result_valid=1. A held strobe pushes once per cycle.
- FIFO:
  - Synchronous write at the push edge.
  - Data becomes visible to the FSM on the following cycle (no write-to-read bypass).
  - Full with no pop: push dropped, contents unchanged, overflow<=1. overflow clears only on reset.
  - Full with pop in the same cycle: push accepted, count unchanged, no overflow.
  - Empty with push: count goes to 1; no pop in that cycle.
- FSM states: IDLE, START, DATA, STOP.
  - Bit-timer counts 0..CLKS_PER_BIT-1; bit index counts 0..7.
  - IDLE: tx=1. If the FIFO is non-empty: pop into an 8-bit shift register, go to START, timer=0.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: tx=shift[0], LSB first, each bit held CLKS_PER_BIT cycles. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then, if the FIFO is non-empty, pop and go directly to START with no idle gap; otherwise go to IDLE.
  - Frame length is exactly 10*CLKS_PER_BIT cycles; back-to-back frames have zero gap.
- Output timing:
  - tx is registered.
  - Latency: a value sampled at edge E is written at E, popped at E+1, and tx falls at E+1.
- busy = (state != IDLE) | (fifo_count != 0), combinational from registers.
- Simultaneous events:
  - A push during a frame never disturbs the frame in progress.
  - A pop and a push in the same cycle update the count by net 0.
- Reset mid-frame: tx returns high immediately (asynchronously) and the FIFO is flushed. No partial-frame resumption after reset is released.
- result_in is synchronous to clk; no synchroniser is required.

Test Plan:
- Reset idle: CLKS_PER_BIT=4. Hold reset=0 for 2 cycles, then release and keep result_in=8'h00 for 100 cycles -> tx=1, busy=0, fifo_count=0, overflow=0 throughout.
- Single byte: CLKS_PER_BIT=4. Change result_in to 8'hA5 at edge E -> tx falls at E+1. Then 4 cycles low; then bits 1,0,1,0,0,1,0,1, 4 cycles each; then 4 cycles high. busy drops at E+41.
- Back-to-back: change result_in 8'h01 -> 8'h02 -> 8'h03 on consecutive edges -> fifo_count peaks at 2. Three contiguous 40-cycle frames with no idle gap, decoded as 01, 02, 03.
- Overflow: DEPTH=4, CLKS_PER_BIT=16. Apply 6 distinct values on 6 consecutive edges -> 1 popped into the shifter, 4 queued, 1 dropped. overflow=1 and stays 1 after all 5 frames finish. Decoded bytes are the first 5 values.
- Strobe mode: CHANGE_DETECT=0. Hold result_in=8'h3C, pulse result_valid for 2 cycles -> two 8'h3C frames. A later change of result_in without a strobe sends nothing.
- Reset mid-frame: assert reset at bit 3 of a frame with 2 entries queued -> tx=1 at once. After release, fifo_count=0, busy=0, and no further frames appear.
